// File: rtl/snoop_responder_if.sv
// Bus, writeback and local-port signals of one snoop responder.
// The slave modport is the responder's view. The master modport is the
// view of whoever drives the bus and the local CPU port.
interface snoop_responder_if;
  logic        hab;
  logic        bus_valid;
  logic [9:0]  bus;
  logic        shared;
  logic        snoop_done;
  logic        wb_valid;
  logic        wb_ready;
  logic [10:0] wb_data;
  logic        loc_we;
  logic [2:0]  loc_index;
  logic [2:0]  loc_tag;
  logic [1:0]  loc_state;
  logic [7:0]  loc_data;
  logic        loc_busy;
  logic        snoop_drop;
  logic        proto_err;
  logic [7:0]  hit_count;

  modport master (
    output hab, bus_valid, bus, wb_ready, loc_we, loc_index, loc_tag, loc_state, loc_data,
    input  shared, snoop_done, wb_valid, wb_data, loc_busy, snoop_drop, proto_err, hit_count
  );

  modport slave (
    input  hab, bus_valid, bus, wb_ready, loc_we, loc_index, loc_tag, loc_state, loc_data,
    output shared, snoop_done, wb_valid, wb_data, loc_busy, snoop_drop, proto_err, hit_count
  );
endinterface

// File: rtl/snoop_responder.sv
// Snoop responder for one CPU's 8-line MSI cache.
// The FSM walks IDLE -> LOOKUP -> RESPOND, and goes through WB when a
// Modified line must be written back.
// Define SNOOP_STATS_EN to build the saturating snoop hit counter.
// Without it, hit_count is tied to zero.
module snoop_responder #(
  parameter logic [1:0] CPU_ID = 2'd0
) (
  input  logic               clock,
  input  logic               clear,
  snoop_responder_if.slave   sif
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOOKUP  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] WB      = 2'd3;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd2;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic [2:0]  tag_q;
  logic [2:0]  idx_q;
  logic        hit_q;
  logic        shared_q;
  logic        wb_valid_q;
  logic [10:0] wb_data_q;
  logic        drop_q;
  logic        perr_q;

  logic [2:0]  line_tag_q  [8];
  logic [1:0]  line_st_q   [8];
  logic [7:0]  line_data_q [8];

  logic        msg_live;
  logic        accept;
  logic        loc_busy;
  logic        loc_take;
  logic        lookup_hit;
  logic [1:0]  cur_st;
  logic [1:0]  new_st;
  logic        need_wb;
  logic        perr_set;
  logic        wb_fire;

  // A message is eligible when snooping is enabled, the message comes from
  // another CPU, and it is not a nop. It is taken only in IDLE.
  assign msg_live   = sif.hab && sif.bus_valid && (sif.bus[9:8] != CPU_ID) && (sif.bus[7:6] != OP_NOP);
  assign accept     = (state_q == IDLE) && msg_live;
  assign loc_busy   = (state_q != IDLE) || accept;
  assign loc_take   = sif.loc_we && !loc_busy;
  assign cur_st     = line_st_q[idx_q];
  assign lookup_hit = (cur_st != ST_I) && (line_tag_q[idx_q] == tag_q);
  assign wb_fire    = (state_q == WB) && wb_valid_q && sif.wb_ready;

  // MSI reaction of the snooped line. It only applies when the lookup hit.
  always_comb begin
    new_st   = cur_st;
    need_wb  = 1'b0;
    perr_set = 1'b0;
    if (hit_q) begin
      case (op_q)
        OP_RD: begin
          new_st  = ST_S;
          need_wb = (cur_st == ST_M);
        end
        OP_WR: begin
          new_st  = ST_I;
          need_wb = (cur_st == ST_M);
        end
        default: begin
          new_st   = ST_I;
          perr_set = (cur_st == ST_M);
        end
      endcase
    end
  end

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = RESPOND;
      RESPOND: state_d = need_wb ? WB : IDLE;
      default: if (wb_fire) state_d = IDLE;
    endcase
  end

  // FSM, captured message, snoop result and writeback registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      op_q       <= OP_NOP;
      tag_q      <= 3'd0;
      idx_q      <= 3'd0;
      hit_q      <= 1'b0;
      shared_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 11'd0;
      drop_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= sif.bus[7:6];
        tag_q <= sif.bus[5:3];
        idx_q <= sif.bus[2:0];
      end
      if ((state_q != IDLE) && msg_live) drop_q <= 1'b1;
      if (state_q == LOOKUP) begin
        hit_q    <= lookup_hit;
        shared_q <= lookup_hit;
      end
      if (state_q == RESPOND) begin
        if (need_wb) begin
          wb_valid_q <= 1'b1;
          wb_data_q  <= {line_tag_q[idx_q], line_data_q[idx_q]};
        end
        if (perr_set) perr_q <= 1'b1;
      end
      if (wb_fire) wb_valid_q <= 1'b0;
    end
  end

  // Line store. A local write is only taken in IDLE, and a snoop commits in
  // RESPOND, so the two writers never collide.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        line_tag_q[i]  <= 3'd0;
        line_st_q[i]   <= ST_I;
        line_data_q[i] <= 8'd0;
      end
    end else if (loc_take) begin
      line_tag_q[sif.loc_index]  <= sif.loc_tag;
      line_st_q[sif.loc_index]   <= sif.loc_state;
      line_data_q[sif.loc_index] <= sif.loc_data;
    end else if (state_q == RESPOND) begin
      line_st_q[idx_q] <= new_st;
    end
  end

`ifdef SNOOP_STATS_EN
  logic [7:0] hit_cnt_q;

  // Saturating count of lookups that hit a valid line.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hit_cnt_q <= 8'd0;
    end else if ((state_q == LOOKUP) && lookup_hit && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign sif.hit_count = hit_cnt_q;
`else
  assign sif.hit_count = 8'h00;
`endif

  assign sif.shared     = shared_q;
  assign sif.snoop_done = ((state_q == RESPOND) && !need_wb) || wb_fire;
  assign sif.wb_valid   = wb_valid_q;
  assign sif.wb_data    = wb_data_q;
  assign sif.loc_busy   = loc_busy;
  assign sif.snoop_drop = drop_q;
  assign sif.proto_err  = perr_q;
endmodule

// File: tb/tb_snoop_responder.sv
// Testbench for snoop_responder.
// A transaction-level MSI model predicts the outputs on every cycle, and
// directed scenarios add literal expectations.
module tb_snoop_responder;
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  snoop_responder_if sif();

  snoop_responder #(.CPU_ID(2'd0)) dut (
    .clock (clock),
    .clear (clear),
    .sif   (sif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  m_tag  [8];
  logic [1:0]  m_st   [8];
  logic [7:0]  m_data [8];
  bit          m_busy, m_wbwait, m_shared, m_drop, m_perr;
  bit          t_hit, t_wb, t_perr;
  logic [10:0] m_wbdata, t_wbdata;
  int          m_edge, m_acc, m_hits;
  int          mi;
  logic [2:0]  mtg;
  logic [1:0]  mop;

  function automatic bit live();
    return sif.hab && sif.bus_valid && (sif.bus[9:8] != 2'd0) && (sif.bus[7:6] != 2'd0);
  endfunction

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        m_tag[i] = 3'd0; m_st[i] = 2'd0; m_data[i] = 8'd0;
      end
      m_busy = 0; m_wbwait = 0; m_shared = 0; m_drop = 0; m_perr = 0;
      t_hit = 0; t_wb = 0; t_perr = 0; m_wbdata = 11'd0; t_wbdata = 11'd0;
      m_edge = 0; m_acc = 0; m_hits = 0;
    end else begin
      m_edge++;
      if (!m_busy) begin
        if (live()) begin
          mi  = int'(sif.bus[2:0]);
          mtg = sif.bus[5:3];
          mop = sif.bus[7:6];
          t_hit    = (m_st[mi] != 2'd0) && (m_tag[mi] == mtg);
          t_wb     = 0;
          t_perr   = 0;
          t_wbdata = {m_tag[mi], m_data[mi]};
          if (t_hit) begin
            if (mop == 2'd1) begin
              t_wb = (m_st[mi] == 2'd2);
              m_st[mi] = 2'd1;
            end else if (mop == 2'd2) begin
              t_wb = (m_st[mi] == 2'd2);
              m_st[mi] = 2'd0;
            end else begin
              t_perr = (m_st[mi] == 2'd2);
              m_st[mi] = 2'd0;
            end
          end
          m_busy = 1;
          m_acc  = m_edge;
        end else if (sif.loc_we) begin
          mi = int'(sif.loc_index);
          m_tag[mi]  = sif.loc_tag;
          m_st[mi]   = sif.loc_state;
          m_data[mi] = sif.loc_data;
        end
      end else begin
        if (live()) m_drop = 1;
        if (m_edge - m_acc == 1) begin
          m_shared = t_hit;
          if (t_hit) m_hits++;
        end else if (m_edge - m_acc == 2) begin
          if (t_perr) m_perr = 1;
          if (t_wb) begin
            m_wbwait = 1;
            m_wbdata = t_wbdata;
          end else begin
            m_busy = 0;
          end
        end else if (m_wbwait && sif.wb_ready) begin
          m_wbwait = 0;
          m_busy   = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_cnt = 0;
  int wbv_cnt  = 0;
  logic [7:0] exp_hc;

  always @(negedge clock) begin
`ifdef SNOOP_STATS_EN
    exp_hc = (m_hits > 255) ? 8'hFF : 8'(m_hits);
`else
    exp_hc = 8'h00;
`endif
    chk("loc_busy",   sif.loc_busy,   m_busy || live());
    chk("snoop_done", sif.snoop_done,
        m_busy && (((m_edge - m_acc == 1) && !t_wb) || (m_wbwait && sif.wb_ready)));
    chk("wb_valid",   sif.wb_valid,   m_wbwait);
    chk("wb_data",    sif.wb_data,    m_wbdata);
    chk("shared",     sif.shared,     m_shared);
    chk("snoop_drop", sif.snoop_drop, m_drop);
    chk("proto_err",  sif.proto_err,  m_perr);
    chk("hit_count",  sif.hit_count,  exp_hc);
    if (sif.snoop_done) done_cnt++;
    if (sif.wb_valid)   wbv_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && sif.loc_busy; n++) tick();
    chk("idle_timeout", sif.loc_busy, 1'b0);
  endtask

  task automatic loc_write(input logic [2:0] i, input logic [2:0] t, input logic [1:0] s, input logic [7:0] d);
    sif.loc_index = i; sif.loc_tag = t; sif.loc_state = s; sif.loc_data = d;
    sif.loc_we = 1'b1;
    wait_idle();
    tick();
    sif.loc_we = 1'b0;
    $display("local write idx=%0d tag=%0d st=%0d data=%h", i, t, s, d);
  endtask

  task automatic snoop(input logic [9:0] m);
    sif.bus = m;
    sif.bus_valid = 1'b1;
    tick();
    sif.bus_valid = 1'b0;
    wait_idle();
    $display("snoop msg=%b shared=%0d drop=%0d perr=%0d", m, sif.shared, sif.snoop_drop, sif.proto_err);
  endtask

  logic [2:0] idx_tag [8];
  int d0, w0;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sif.hab = 1'b1; sif.bus_valid = 1'b0; sif.bus = 10'd0; sif.wb_ready = 1'b0;
    sif.loc_we = 1'b0; sif.loc_index = 3'd0; sif.loc_tag = 3'd0; sif.loc_state = 2'd0; sif.loc_data = 8'd0;
    idx_tag = '{3'd2, 3'd0, 3'd4, 3'd5, 3'd0, 3'd7, 3'd1, 3'd0};
    repeat (3) tick();
    clear = 1'b0;
    tick();
    // Reset state.
    chk("rst_shared", sif.shared, 1'b0);
    chk("rst_wb_valid", sif.wb_valid, 1'b0);
    chk("rst_wb_data", sif.wb_data, 11'd0);
    chk("rst_drop", sif.snoop_drop, 1'b0);
    chk("rst_perr", sif.proto_err, 1'b0);
    chk("rst_hit_count", sif.hit_count, 8'h00);

    // Read miss from CPU1 on a Modified line, with a stalled writeback.
    loc_write(3'd3, 3'd5, 2'd2, 8'hA5);
    d0 = done_cnt;
    sif.bus = 10'b01_01_101_011; sif.bus_valid = 1'b1;
    tick();                      // LOOKUP
    sif.bus_valid = 1'b0;
    tick();                      // RESPOND
    chk("t1_shared", sif.shared, 1'b1);
    tick();                      // WB, wb_ready low
    chk("t1_wb_valid_a", sif.wb_valid, 1'b1);
    chk("t1_wb_data", sif.wb_data, 11'b101_10100101);
    tick();                      // WB, wb_ready still low
    chk("t1_wb_valid_b", sif.wb_valid, 1'b1);
    sif.wb_ready = 1'b1;
    tick();
    sif.wb_ready = 1'b0;
    chk("t1_wb_released", sif.wb_valid, 1'b0);
    chk("t1_done_pulses", done_cnt - d0, 1);
    $display("snoop msg=0101101011 shared=%0d wb_data=%b", sif.shared, sif.wb_data);
    w0 = wbv_cnt;
    snoop(10'b01_01_101_011);    // line 3 is now S: hit, no writeback
    chk("t1_line3_S_shared", sif.shared, 1'b1);
    chk("t1_line3_S_no_wb", wbv_cnt - w0, 0);

    // Write miss from CPU2 on a Shared line.
    loc_write(3'd0, 3'd2, 2'd1, 8'h11);
    w0 = wbv_cnt;
    snoop(10'b10_10_010_000);
    chk("t2_shared", sif.shared, 1'b1);
    chk("t2_no_wb", wbv_cnt - w0, 0);
    snoop(10'b01_01_010_000);
    chk("t2_line0_I", sif.shared, 1'b0);

    // Own-source message and a message with hab low are both ignored.
    snoop(10'b01_01_101_011);
    d0 = done_cnt;
    snoop(10'b00_10_101_011);
    sif.hab = 1'b0;
    snoop(10'b01_10_101_011);
    sif.hab = 1'b1;
    chk("t3_no_snoop", done_cnt - d0, 0);
    chk("t3_shared_kept", sif.shared, 1'b1);
    chk("t3_no_drop", sif.snoop_drop, 1'b0);
    snoop(10'b01_01_101_011);
    chk("t3_line3_still_S", sif.shared, 1'b1);

    // A second message while busy, plus a local write stalled during LOOKUP.
    d0 = done_cnt;
    sif.bus = 10'b01_01_101_011; sif.bus_valid = 1'b1;
    tick();                      // LOOKUP
    sif.bus = 10'b10_10_101_011;
    sif.loc_index = 3'd3; sif.loc_tag = 3'd5; sif.loc_state = 2'd0; sif.loc_data = 8'h00;
    sif.loc_we = 1'b1;
    #1 chk("t4_loc_busy", sif.loc_busy, 1'b1);
    tick();                      // RESPOND
    sif.bus_valid = 1'b0;
    chk("t4_drop", sif.snoop_drop, 1'b1);
    wait_idle();
    chk("t4_first_hit", sif.shared, 1'b1);
    chk("t4_first_done", done_cnt - d0, 1);
    tick();                      // stalled local write lands now
    sif.loc_we = 1'b0;
    snoop(10'b01_01_101_011);
    chk("t4_line3_written_I", sif.shared, 1'b0);

    // Invalidate hitting a Modified line.
    loc_write(3'd5, 3'd7, 2'd2, 8'h3C);
    w0 = wbv_cnt;
    snoop(10'b10_11_111_101);
    chk("t5_perr", sif.proto_err, 1'b1);
    chk("t5_no_wb", wbv_cnt - w0, 0);
    chk("t5_shared", sif.shared, 1'b1);
    snoop(10'b01_01_111_101);
    chk("t5_line5_I", sif.shared, 1'b0);

    // Reset while a writeback is pending.
    loc_write(3'd6, 3'd1, 2'd2, 8'h0F);
    sif.wb_ready = 1'b0;
    sif.bus = 10'b01_10_001_110; sif.bus_valid = 1'b1;
    tick();
    sif.bus_valid = 1'b0;
    for (int n = 0; n < 10 && !sif.wb_valid; n++) tick();
    chk("t5_wb_up", sif.wb_valid, 1'b1);
    #1 clear = 1'b1;
    #1 chk("t5_wb_clear", sif.wb_valid, 1'b0);
    chk("t5_perr_clear", sif.proto_err, 1'b0);
    chk("t5_drop_clear", sif.snoop_drop, 1'b0);
    tick();
    clear = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      snoop({2'b01, 2'b01, idx_tag[i], iv});
      chk("t5_all_I", sif.shared, 1'b0);
    end

    // Hit counter saturation.
    loc_write(3'd2, 3'd4, 2'd1, 8'h77);
    for (int n = 0; n < 300; n++) snoop(10'b01_01_100_010);
`ifdef SNOOP_STATS_EN
    chk("t6_hit_count", sif.hit_count, 8'hFF);
`else
    chk("t6_hit_count", sif.hit_count, 8'h00);
`endif
    chk("t6_shared", sif.shared, 1'b1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snoop_responder.md
# snoop_responder

Snoop-side controller for one processor's cache in the three-CPU snooping coherence system. It listens to the shared 10-bit bus driven by the system sequencer, looks up the addressed line in a private 8-line MSI tag/state store, and applies the state transition. It reports whether the line is shared and emits a writeback when the snooped line is Modified. The local CPU installs and updates lines through a separate port that stalls while a snoop is in progress.

## Interface
- CPU_ID, 2'd0, this responder's processor id; bus messages with this source id are ignored.
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- hab  in  1  snoop enable; when low, bus messages are not accepted.
- bus_valid  in  1  bus carries a message this cycle.
- bus  in  10  message: [9:8] source id, [7:6] op (00 nop, 01 read miss, 10 write miss, 11 invalidate), [5:3] tag, [2:0] index.
- shared  out  1  last accepted snoop hit a valid line (S or M).
- snoop_done  out  1  one-cycle pulse when the snoop fully completes.
- wb_valid  out  1  writeback data available.
- wb_ready  in  1  consumer accepts writeback.
- wb_data  out  11  {tag[2:0], data[7:0]} of the evicted Modified line.
- loc_we  in  1  local line write request.
- loc_index  in  3, loc_tag  in  3, loc_state  in  2 (00 I, 01 S, 10 M), loc_data  in  8: local write payload.
- loc_busy  out  1  local write not taken this cycle.
- snoop_drop  out  1  sticky: a message was lost while busy.
- proto_err  out  1  sticky: invalidate hit a Modified line.
- hit_count  out  8  snoop hit counter (see Configuration).

## Operation
- FSM states: IDLE, LOOKUP, RESPOND, WB.
- IDLE: accept a message when hab && bus_valid && bus[9:8]!=CPU_ID && bus[7:6]!=00. The message is registered and the FSM goes to LOOKUP. Nop and own-source messages are ignored with no state change.
- LOOKUP: read line[index]. A hit is state!=I && tag==msg tag. Update shared <= hit, then go to RESPOND.
- RESPOND: apply the transition below. Go to WB if a writeback is needed; otherwise pulse snoop_done and return to IDLE.
  - Read miss: S stays S. M becomes S with writeback.
  - Write miss: S becomes I. M becomes I with writeback.
  - Invalidate: S becomes I. M becomes I with no writeback, and proto_err is set.
  - Miss: no change.
- WB: hold wb_valid and a stable wb_data until wb_valid && wb_ready. In that cycle, pulse snoop_done and return to IDLE.
- loc_busy = (state!=IDLE) || (state==IDLE && snoop accepted this cycle).
- A local write with !loc_busy updates line[loc_index] on the clock edge. A stalled local write is not queued; the requester holds loc_we.
- A bus_valid from another source with a non-nop op, arriving while state!=IDLE, is dropped and sets snoop_drop. A message arriving while hab=0 is ignored without setting snoop_drop.
- shared holds its value until the next LOOKUP.

## Timing
- Reset (clear=1, asynchronous):
  - State returns to IDLE.
  - All lines are set to I.
  - shared, snoop_done, wb_valid, snoop_drop, proto_err and hit_count go to 0.
  - wb_data goes to 0.
- Reset mid-operation aborts any pending writeback, and wb_valid falls immediately.
- Snoop accepted at edge N: LOOKUP in N+1, and shared is valid after edge N+2.
- Without a writeback, snoop_done is high in the RESPOND cycle and IDLE is reached at edge N+3.
- With a writeback, wb_valid rises after edge N+3 and returns to 0 on the handshake edge.
- Minimum spacing between accepted snoops: 3 cycles.
- A line state update commits at the RESPOND edge.

## Configuration
- SNOOP_STATS_EN defined: hit_count increments by 1 at each LOOKUP hit. It saturates at 8'hFF and is cleared by clear.
- SNOOP_STATS_EN undefined: hit_count is tied to 8'h00 and no counter logic is built.

## Test plan
- Install line index 3 (tag 5, M, data 8'hA5) via the local port. Then bus 10'b01_01_101_011 (CPU1 read miss). Required: shared=1, wb_data=11'b101_10100101 with wb_valid held across 2 cycles of wb_ready=0, line 3 ends in S, and a single snoop_done pulse.
- Install index 0 (tag 2, S). Write miss tag 2 from CPU2. Required: shared=1, no wb_valid, line 0 becomes I, and a subsequent read miss for it gives shared=0.
- Message with source == CPU_ID, and a message with hab=0. Required: no state change, shared unchanged, snoop_drop=0.
- Second message one cycle after accept. Required: it is ignored, snoop_drop=1, and the first snoop completes normally. Assert loc_we during LOOKUP: loc_busy=1 and the line is unchanged until IDLE.
- Invalidate hitting an M line. Required: line becomes I, proto_err=1, no writeback. Then assert clear during WB of another snoop: wb_valid=0 immediately and all lines are I.
- With SNOOP_STATS_EN: 300 hits give hit_count=8'hFF. Without it: hit_count=0 throughout.
